// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver for the SoC console line: 2-flop synchronizer, bit-timing FSM
// and a small byte FIFO with a valid/ready read side plus framing/overflow flags.
module uart_rx_monitor #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          clr_overflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_e;

  logic          rx_meta_q, rx_s_q, rx_prev_q;
  logic [2:0]    settle_q;
  logic          fall_c;

  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          push_q;
  logic          frame_err_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          full_c, pop_c, push_ok_c, drop_c;

  // Synchronizer plus edge flop; settle_q marks when the flops hold real line samples,
  // so a line already low when reset releases is not mistaken for a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      settle_q  <= 3'b000;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      settle_q  <= {settle_q[1:0], 1'b1};
    end
  end

  assign fall_c = settle_q[2] & rx_prev_q & ~rx_s_q;

  // Bit-timing FSM; timer restarts from zero on every state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fall_c) begin
            state_q <= ST_START;
            timer_q <= '0;
          end
        end
        ST_START: begin
          if (timer_q == HALF_M1) begin
            timer_q <= '0;
            if (!rx_s_q) begin
              state_q   <= ST_DATA;
              bit_idx_q <= '0;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_DATA: begin
          if (timer_q == FULL_M1) begin
            timer_q            <= '0;
            shift_q[bit_idx_q] <= rx_s_q;
            if (bit_idx_q == 3'd7) begin
              state_q <= ST_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_STOP: begin
          if (timer_q == FULL_M1) begin
            timer_q <= '0;
            if (rx_s_q) begin
              push_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ST_BREAK;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_BREAK: begin
          if (rx_s_q) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          timer_q <= '0;
        end
      endcase
    end
  end

  assign full_c    = (count_q == CW'(FIFO_DEPTH));
  assign pop_c     = rx_ready && (count_q != '0);
  assign push_ok_c = push_q && (!full_c || pop_c);
  assign drop_c    = push_q && full_c && !pop_c;

  // Byte FIFO: shift_q stays untouched until the next frame's data phase, so it is
  // safe to write one cycle after the stop sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok_c) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_ok_c, pop_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop_c) overflow_q <= 1'b1;
      else if (clr_overflow) overflow_q <= 1'b0;
    end
  end

  assign rx_data   = mem_q[rd_ptr_q];
  assign rx_valid  = (count_q != '0);
  assign rx_count  = count_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Self-checking bench for uart_rx_monitor: serial driver, handshake monitor and a
// queue-based expectation of delivered bytes, occupancy and flags.
module tb_uart_rx_monitor;

  localparam int unsigned CPB   = 104;
  localparam int unsigned DEPTH = 16;
  // Clocks from driving the start bit to the stop-bit sample edge: two sync flops,
  // one edge-detect flop, half a bit to mid-start, then nine full bits.
  localparam int unsigned STOP_SAMPLE = 3 + CPB / 2 + 9 * CPB;

  logic       clk, rst_n, rx;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [4:0] rx_count;
  logic       frame_err, overflow, clr_overflow;
  logic       ready_man, ready_rnd, rnd_en;

  assign rx_ready = rnd_en ? ready_rnd : ready_man;

  uart_rx_monitor #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_count     (rx_count),
    .frame_err    (frame_err),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks, failures;
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  int         kept, hs, ferr_cnt, max_cnt, ferr0;
  logic       mdl_ovf;
  logic       prev_hold;
  logic [7:0] prev_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference FIFO: a byte is kept unless occupancy (kept minus popped) is at capacity.
  task automatic model_push(input logic [7:0] b);
    if (kept - hs >= int'(DEPTH)) mdl_ovf = 1'b1;
    else begin
      exp_q.push_back(b);
      kept++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int stop_low);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    if (stop_low > 0) begin
      rx = 1'b0;
      tick(stop_low * CPB);
    end
    rx = 1'b1;
    tick(CPB);
    if (stop_low == 0) model_push(b);
  endtask

  task automatic compare_stream(input string tag);
    check_eq({tag, "_len"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check_eq(tag, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rx_valid && rx_ready) begin
          obs_q.push_back(rx_data);
          hs++;
        end
        if (frame_err) ferr_cnt++;
        if (int'(rx_count) > max_cnt) max_cnt = int'(rx_count);
        if (prev_hold && rx_valid) check_eq("data_stable", rx_data, prev_data);
        prev_hold = rx_valid && !rx_ready;
        prev_data = rx_data;
      end else begin
        prev_hold = 1'b0;
      end
    end
  endtask

  task automatic ready_noise();
    forever begin
      @(posedge clk);
      #1;
      ready_rnd = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, rx_valid, 0);
    check_eq({tag, "_count"}, rx_count, 0);
    check_eq({tag, "_data"}, rx_data, 0);
    check_eq({tag, "_ferr"}, frame_err, 0);
    check_eq({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    kept = 0; hs = 0; ferr_cnt = 0; max_cnt = 0; ferr0 = 0;
    mdl_ovf = 1'b0; prev_hold = 1'b0; prev_data = '0;
    rx = 1'b1; ready_man = 1'b0; ready_rnd = 1'b0; rnd_en = 1'b0;
    clr_overflow = 1'b0; rst_n = 1'b0;
    fork
      monitor_loop();
      ready_noise();
    join_none

    tick(5);
    check_reset_outputs("por");
    rst_n = 1'b1;
    tick(10);

    // Single byte
    ready_man = 1'b1;
    ferr0 = ferr_cnt;
    send_byte(8'h55, 0);
    tick(20);
    compare_stream("single");
    check_eq("single_ferr", ferr_cnt - ferr0, 0);

    // Back-to-back stream
    max_cnt = 0;
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h3C, 0);
    tick(20);
    compare_stream("stream");
    check_eq("stream_maxcnt", max_cnt, 1);

    // Framing error with long break, then recovery
    ferr0 = ferr_cnt;
    send_byte(8'h41, 3);
    tick(20);
    check_eq("ferr_pulses", ferr_cnt - ferr0, 1);
    check_eq("ferr_count", rx_count, 0);
    send_byte(8'h42, 0);
    tick(20);
    compare_stream("after_ferr");

    // Short glitch on idle line
    ferr0 = ferr_cnt;
    rx = 1'b0;
    tick(20);
    rx = 1'b1;
    tick(300);
    check_eq("glitch_ferr", ferr_cnt - ferr0, 0);
    check_eq("glitch_count", rx_count, 0);
    compare_stream("glitch");

    // Overflow: 17 bytes into a 16-deep FIFO with no consumer
    ready_man = 1'b0;
    for (int k = 1; k <= 17; k++) send_byte(8'(k), 0);
    tick(5);
    check_eq("ovf_count", rx_count, kept - hs);
    check_eq("ovf_flag", overflow, mdl_ovf);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    mdl_ovf = 1'b0;
    check_eq("ovf_clr", overflow, mdl_ovf);

    // Full FIFO: single pop exactly on the push cycle of 0x77
    fork
      send_byte(8'h77, 0);
      begin
        tick(STOP_SAMPLE);
        ready_man = 1'b1;
        tick(1);
        ready_man = 1'b0;
      end
    join
    tick(5);
    check_eq("full_count", rx_count, kept - hs);
    check_eq("full_ovf", overflow, mdl_ovf);
    ready_man = 1'b1;
    tick(40);
    compare_stream("drain");
    check_eq("drain_count", rx_count, 0);

    // Random bytes, gaps and consumer back-pressure
    rnd_en = 1'b1;
    ferr0 = ferr_cnt;
    for (int k = 0; k < 8; k++) begin
      send_byte(8'($urandom), 0);
      tick(int'($urandom_range(0, 30)));
    end
    rnd_en = 1'b0;
    ready_man = 1'b1;
    tick(40);
    compare_stream("random");
    check_eq("random_count", rx_count, 0);
    check_eq("random_ferr", ferr_cnt - ferr0, 0);

    // Mid-frame reset with a byte already queued, then line held low across release
    ready_man = 1'b0;
    send_byte(8'hC3, 0);
    tick(5);
    check_eq("pre_rst_valid", rx_valid, 1);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = ((8'h99 >> i) & 8'h01) != 0;
      tick(CPB);
    end
    rx = 1'b1;
    tick(CPB / 2);
    rst_n = 1'b0;
    rx = 1'b0;
    #2;
    check_reset_outputs("midrst");
    tick(3);
    check_reset_outputs("inrst");
    obs_q.delete();
    exp_q.delete();
    kept = 0; hs = 0; mdl_ovf = 1'b0;
    ferr0 = ferr_cnt;
    rst_n = 1'b1;
    tick(300);
    rx = 1'b1;
    tick(50);
    check_eq("lowline_ferr", ferr_cnt - ferr0, 0);
    check_eq("lowline_count", rx_count, 0);
    send_byte(8'h12, 0);
    tick(20);
    ready_man = 1'b1;
    tick(10);
    compare_stream("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
